// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder peripheral: register map, CTRL/STATUS bits, step decode.
// Optional glitch filter is enabled by defining QENC_GLITCH_FILTER_EN (see quad_enc_filter).
package quad_enc_pkg;

  localparam logic [1:0] ADDR_POSITION = 2'd0;
  localparam logic [1:0] ADDR_VELOCITY = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_CLR = 2;

  localparam int STAT_ERR = 0;
  localparam int STAT_DIR = 1;
  localparam int STAT_VV  = 2;

  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} step_t;

  // AB = {B,A}; Gray 00->01->11->10 maps to phase 0..3, so a step is a +/-1 phase difference mod 4
  function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] p;
    logic [1:0] c;
    p = {prev_ab[1], ^prev_ab};
    c = {cur_ab[1], ^cur_ab};
    if (c == p)                decode_step = STEP_NONE;
    else if (c == p + 2'd1)    decode_step = STEP_FWD;
    else if (c == p - 2'd1)    decode_step = STEP_REV;
    else                       decode_step = STEP_ERR;
  endfunction

endpackage

// File: rtl/quad_encoder_decoder_if.sv
// Avalon-MM slave bus of the quadrature encoder peripheral.
interface quad_encoder_decoder_if;

  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
  modport slave  (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);

endinterface

// File: rtl/quad_enc_filter.sv
// 2-FF synchroniser for the A/B pins plus an optional per-channel glitch filter.
// Define QENC_GLITCH_FILTER_EN to require FILT_LEN stable cycles before a level is accepted.
module quad_enc_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pin_in,
  output logic [1:0] ab_out,
  output logic       ab_valid
);

  if (FILT_LEN < 1) begin : g_param_check
    $error("quad_enc_filter: FILT_LEN must be >= 1");
  end

`ifdef QENC_GLITCH_FILTER_EN
  localparam int VLD_W = 3;
`else
  localparam int VLD_W = 2;
`endif

  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [VLD_W-1:0] vld_q;

  // vld_q marks when the pipeline holds real pin samples rather than reset zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[VLD_W-2:0], 1'b1};
    end
  end

`ifdef QENC_GLITCH_FILTER_EN
  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [1:0]            filt_q, filt_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Until primed the filter simply adopts the synchronised level so start-up never looks like a step
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (!vld_q[VLD_W-1]) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ab_out   = filt_q;
  assign ab_valid = vld_q[VLD_W-1];
`else
  assign ab_out   = sync2_q;
  assign ab_valid = vld_q[VLD_W-1];
`endif

endmodule

// File: rtl/quad_encoder_decoder.sv
// Avalon-MM quadrature decoder: 4x position count, windowed velocity, CTRL/STATUS registers, irq.
// Glitch filtering in front of the decoder is selected with QENC_GLITCH_FILTER_EN.
module quad_encoder_decoder
  import quad_enc_pkg::*;
#(
  parameter int VEL_WINDOW = 50000,
  parameter int FILT_LEN   = 4
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [1:0]                   encoder_in,
  quad_encoder_decoder_if.slave        avs,
  output logic                         irq
);

  if (VEL_WINDOW < 2) begin : g_param_check
    $error("quad_encoder_decoder: VEL_WINDOW must be >= 2");
  end

  localparam int WIN_W = $clog2(VEL_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);

  logic [1:0] ab;
  logic       ab_valid;

  quad_enc_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .pin_in   (encoder_in),
    .ab_out   (ab),
    .ab_valid (ab_valid)
  );

  logic [1:0]       prev_ab_q, prev_ab_d;
  logic             prev_vld_q, prev_vld_d;
  logic [31:0]      position_q, position_d;
  logic [31:0]      delta_q, delta_d;
  logic [31:0]      velocity_q, velocity_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             en_q, en_d, ie_q, ie_d;
  logic             err_q, err_d, dir_q, dir_d, vv_q, vv_d, irq_q, irq_d;

  step_t       step;
  logic        wr_pos, wr_ctrl, wr_stat, rd_vel, clr, step_fwd, step_rev, terminal;
  logic [31:0] step_val;

  // Register writes (preset/CLR) take priority over a same-cycle step; VV set beats its clear
  always_comb begin
    prev_ab_d  = ab;
    prev_vld_d = ab_valid;
    step       = prev_vld_q ? decode_step(prev_ab_q, ab) : STEP_NONE;

    wr_pos   = avs.avs_write && (avs.avs_address == ADDR_POSITION);
    wr_ctrl  = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    wr_stat  = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    rd_vel   = avs.avs_read  && (avs.avs_address == ADDR_VELOCITY);
    clr      = wr_ctrl && avs.avs_writedata[CTRL_CLR];
    step_fwd = en_q && (step == STEP_FWD) && !clr && !wr_pos;
    step_rev = en_q && (step == STEP_REV) && !clr && !wr_pos;
    step_val = step_fwd ? 32'd1 : (step_rev ? 32'hFFFF_FFFF : 32'd0);
    terminal = (win_cnt_q == WIN_LAST);

    position_d = position_q + step_val;
    delta_d    = delta_q + step_val;
    velocity_d = velocity_q;
    win_cnt_d  = win_cnt_q + 1'b1;
    if (terminal) begin
      velocity_d = delta_q + step_val;
      delta_d    = '0;
      win_cnt_d  = '0;
    end
    if (wr_pos) position_d = avs.avs_writedata;
    if (clr) begin
      position_d = '0;
      delta_d    = '0;
      win_cnt_d  = '0;
    end

    en_d = en_q;
    ie_d = ie_q;
    if (wr_ctrl) begin
      en_d = avs.avs_writedata[CTRL_EN];
      ie_d = avs.avs_writedata[CTRL_IE];
    end

    dir_d = step_fwd ? 1'b1 : (step_rev ? 1'b0 : dir_q);
    err_d = err_q;
    vv_d  = vv_q;
    if (wr_stat && avs.avs_writedata[STAT_ERR]) err_d = 1'b0;
    if (en_q && (step == STEP_ERR))             err_d = 1'b1;
    if (rd_vel || (wr_stat && avs.avs_writedata[STAT_VV])) vv_d = 1'b0;
    if (terminal)                               vv_d = 1'b1;
    irq_d = vv_d && ie_d;

    readdata_d = readdata_q;
    if (avs.avs_read) begin
      case (avs.avs_address)
        ADDR_POSITION: readdata_d = position_q;
        ADDR_VELOCITY: readdata_d = velocity_q;
        ADDR_CTRL:     readdata_d = {29'd0, 1'b0, ie_q, en_q};
        default:       readdata_d = {29'd0, vv_q, dir_q, err_q};
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev_ab_q  <= '0;
      prev_vld_q <= 1'b0;
      position_q <= '0;
      delta_q    <= '0;
      velocity_q <= '0;
      readdata_q <= '0;
      win_cnt_q  <= '0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      err_q      <= 1'b0;
      dir_q      <= 1'b0;
      vv_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      prev_ab_q  <= prev_ab_d;
      prev_vld_q <= prev_vld_d;
      position_q <= position_d;
      delta_q    <= delta_d;
      velocity_q <= velocity_d;
      readdata_q <= readdata_d;
      win_cnt_q  <= win_cnt_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      err_q      <= err_d;
      dir_q      <= dir_d;
      vv_q       <= vv_d;
      irq_q      <= irq_d;
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign irq              = irq_q;

endmodule
